// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and frame constants for the UART transmit path
package uart_pkg;

    // Serializer states: IDLE waits for a byte, START/DATA/STOP shape one 8N1 frame.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // 100 MHz / 115200 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage

// File: rtl/uart_tx_shifter.sv
// rtl/uart_tx_shifter.sv - 8N1 serializer: FSM, baud counter, shift register, registered tx
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   fifo_empty  : FIFO holds no bytes (registered in the FIFO)
//   pop         : one-cycle request to take byte_in and advance the FIFO read pointer
//   byte_in     : byte at the FIFO head, loaded into the shift register on pop
//   busy        : serializer is in START/DATA/STOP
//   tx          : serial line, idles high, driven straight from a flop
module uart_tx_shifter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fifo_empty,
    output logic       pop,
    input  logic [7:0] byte_in,
    output logic       busy,
    output logic       tx
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0]  LAST_STOP = IDX_W'(STOP_BITS - 1);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              bit_done;

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        bit_done  = (baud_q == BAUD_LAST);

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = byte_in;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == LAST_DATA) begin
                        bit_idx_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                // bit_idx is reused to count stop bits.
                if (bit_done) begin
                    baud_d = '0;
                    if (bit_idx_q == LAST_STOP) begin
                        bit_idx_d = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // tx is decoded from the next state so the line changes on the same edge
        // as the state register, yet leaves the design from a flop.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign tx   = tx_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding an 8N1 UART transmitter
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   data_in    : byte to transmit
//   wr_en      : write strobe, one byte per cycle while high
//   full       : FIFO holds DEPTH entries (registered)
//   empty      : FIFO holds 0 entries (registered)
//   overflow   : one-cycle pulse after a write was dropped because the FIFO was full
//   busy       : serializer is in START/DATA/STOP
//   tx         : serial line, idles high
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DEPTH        = 8,
    parameter int ADDR_W       = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       wr_en,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    output logic       busy,
    output logic       tx
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              overflow_q, overflow_d;
    logic              wr_accept;
    logic              pop;

    always_comb begin
        // Uses the registered full flag, so a pop in this same cycle cannot
        // make room for a write that arrives while full.
        wr_accept  = wr_en && !full_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = wr_en && full_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        case ({wr_accept, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is left unreset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    uart_tx_shifter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (empty_q),
        .pop        (pop),
        .byte_in    (mem_q[rd_ptr_q]),
        .busy       (busy),
        .tx         (tx)
    );

    assign full     = full_q;
    assign empty    = empty_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo at CLKS_PER_BIT=4
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic       wr_en;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       busy;
    logic       tx;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    uart_tx_fifo #(
        .CLKS_PER_BIT (4),
        .DEPTH        (8),
        .ADDR_W       (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .wr_en    (wr_en),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .busy     (busy),
        .tx       (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Waits (bounded) for a start bit, then samples each
    // bit near its centre. Returns at the negedge in the middle of the stop bit.
    task automatic get_frame(input int max_wait, output logic [7:0] b,
                             output int t0, output logic ok);
        b  = '0;
        t0 = 0;
        ok = 1'b0;
        for (int i = 0; i < max_wait && tx !== 1'b0; i++) @(negedge clk);
        if (tx === 1'b0) begin
            ok = 1'b1;
            t0 = cyc;
            repeat (2) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                repeat (4) @(negedge clk);
                b[k] = tx;
            end
            repeat (4) @(negedge clk);
            chk("stop_bit", {31'd0, tx}, 32'd1);
        end
    endtask

    logic [7:0] fb;
    logic       fok;
    int         t0, t_prev, bad, k;
    logic [9:0] fr;
    logic [7:0] wrap_tbl [12];

    initial begin
        wrap_tbl = '{8'h01, 8'h80, 8'hFF, 8'h55, 8'hAA, 8'h3C,
                     8'hC3, 8'h0F, 8'hF0, 8'h96, 8'h69, 8'h7E};
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        data_in = 8'h00;

        // Reset state
        @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle 20 cycles
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || empty !== 1'b1 || full !== 1'b0 ||
                busy !== 1'b0 || overflow !== 1'b0) bad++;
        end
        chk("idle_quiet", bad, 0);

        // Single write 0xA5: exact cycle-by-cycle waveform
        wr_en   = 1'b1;
        data_in = 8'hA5;
        @(negedge clk);            // edge N done
        wr_en = 1'b0;
        chk("a5_empty_after_N", {31'd0, empty}, 32'd0);
        chk("a5_tx_after_N", {31'd0, tx}, 32'd1);
        chk("a5_busy_after_N", {31'd0, busy}, 32'd0);
        @(negedge clk);            // edge N+1 done: pop
        chk("a5_empty_after_pop", {31'd0, empty}, 32'd1);
        fr = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("a5_tx_%0d", i), {31'd0, tx}, {31'd0, fr[i/4]});
            chk($sformatf("a5_busy_%0d", i), {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        chk("a5_busy_end", {31'd0, busy}, 32'd0);
        chk("a5_tx_end", {31'd0, tx}, 32'd1);

        // Burst: primer 0xFF keeps the serializer busy, then 0x00..0x07
        repeat (3) @(negedge clk);
        wr_en   = 1'b1;
        data_in = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            data_in = 8'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
        chk("burst_full", {31'd0, full}, 32'd1);
        chk("burst_no_overflow", {31'd0, overflow}, 32'd0);
        k = 0;
        while (full !== 1'b0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("burst_full_clear_delay", k, 34);
        chk("burst_tx_start_at_clear", {31'd0, tx}, 32'd0);
        t_prev = 0;
        for (int i = 0; i < 8; i++) begin
            get_frame(60, fb, t0, fok);
            chk($sformatf("burst_found_%0d", i), {31'd0, fok}, 32'd1);
            chk($sformatf("burst_byte_%0d", i), {24'd0, fb}, i);
            if (i > 0) chk($sformatf("burst_gap_%0d", i), t0 - t_prev, 41);
            t_prev = t0;
        end

        // Overflow: primer 0xEE, then 9 writes 0x10..0x18, the last one dropped
        repeat (6) @(negedge clk);
        wr_en   = 1'b1;
        data_in = 8'hEE;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 8) chk("ovf_before_9th", {31'd0, overflow}, 32'd0);
            data_in = 8'h10 + 8'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
        chk("ovf_pulse", {31'd0, overflow}, 32'd1);
        chk("ovf_full", {31'd0, full}, 32'd1);
        @(negedge clk);
        chk("ovf_pulse_end", {31'd0, overflow}, 32'd0);
        k = 0;
        while (full !== 1'b0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("ovf_tx_start_at_clear", {31'd0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            get_frame(60, fb, t0, fok);
            chk($sformatf("ovf_found_%0d", i), {31'd0, fok}, 32'd1);
            chk($sformatf("ovf_byte_%0d", i), {24'd0, fb}, 32'h10 + i);
        end
        get_frame(100, fb, t0, fok);
        chk("ovf_no_ninth_frame", {31'd0, fok}, 32'd0);
        chk("ovf_empty_end", {31'd0, empty}, 32'd1);

        // Pointer wrap: pairs of writes, each pair drained before the next
        for (int i = 0; i < 12; i += 2) begin
            wr_en   = 1'b1;
            data_in = wrap_tbl[i];
            @(negedge clk);
            data_in = wrap_tbl[i+1];
            @(negedge clk);
            wr_en = 1'b0;
            for (int j = 0; j < 2; j++) begin
                get_frame(60, fb, t0, fok);
                chk($sformatf("wrap_found_%0d", i + j), {31'd0, fok}, 32'd1);
                chk($sformatf("wrap_byte_%0d", i + j), {24'd0, fb}, {24'd0, wrap_tbl[i+j]});
            end
        end

        // Reset mid-DATA of frame 0x5A with three bytes queued
        repeat (4) @(negedge clk);
        wr_en = 1'b1;
        data_in = 8'h5A;
        @(negedge clk);
        data_in = 8'h11;
        @(negedge clk);
        data_in = 8'h22;
        @(negedge clk);
        data_in = 8'h33;
        @(negedge clk);
        wr_en = 1'b0;
        k = 0;
        while (tx !== 1'b0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        // Start bit began up to three cycles ago; step into the data field
        // and find bit0 (0 for 0x5A), five negedges after the start bit began.
        repeat (5 - 3) @(negedge clk);
        chk("mid_reset_busy_before", {31'd0, busy}, 32'd1);
        chk("mid_reset_tx_before", {31'd0, tx}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_tx", {31'd0, tx}, 32'd1);
        chk("mid_reset_empty", {31'd0, empty}, 32'd1);
        chk("mid_reset_busy", {31'd0, busy}, 32'd0);
        chk("mid_reset_full", {31'd0, full}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || empty !== 1'b1) bad++;
        end
        chk("post_reset_quiet", bad, 0);
        wr_en   = 1'b1;
        data_in = 8'hC3;
        @(negedge clk);
        wr_en = 1'b0;
        get_frame(10, fb, t0, fok);
        chk("post_reset_found", {31'd0, fok}, 32'd1);
        chk("post_reset_byte", {24'd0, fb}, 32'hC3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
